// File: rtl/code2421_seq_checker.sv
// Receive-side checker for a 2421 (Aiken) mod-10 up-counter stream: decodes to BCD,
// rejects illegal codewords, locks onto the count sequence and tallies wraps/errors.
module code2421_seq_checker #(
  parameter int LOCK_N = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        code_in,
  input  logic              in_valid,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              illegal,
  output logic              seq_err,
  output logic              locked,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        fsm_state
);

  // Handshake: in_valid is a one-way strobe with no back-pressure; code_in is consumed
  // on every rising edge where in_valid=1, and all responses appear one clock later.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_W = 4'(LOCK_N);

  state_t            state, state_nx;
  logic [3:0]        succ, succ_nx, succ_inc;
  logic [3:0]        ref_digit, ref_nx, exp_digit;
  logic [3:0]        dec;
  logic              legal;
  logic [3:0]        digit_nx;
  logic              dv_nx, ill_nx, seq_nx, err_inc;
  logic [WRAP_W-1:0] wrap_nx;
  logic [ERR_W-1:0]  err_nx;

  always_comb begin
    legal = 1'b1;
    dec   = 4'd0;
    case (code_in)
      4'b0000: dec = 4'd0;
      4'b0001: dec = 4'd1;
      4'b0010: dec = 4'd2;
      4'b0011: dec = 4'd3;
      4'b0100: dec = 4'd4;
      4'b1011: dec = 4'd5;
      4'b1100: dec = 4'd6;
      4'b1101: dec = 4'd7;
      4'b1110: dec = 4'd8;
      4'b1111: dec = 4'd9;
      default: legal = 1'b0;
    endcase
  end

  assign exp_digit = (ref_digit == 4'd9) ? 4'd0 : ref_digit + 4'd1;
  assign succ_inc  = succ + 4'd1;

  always_comb begin
    state_nx = state;
    succ_nx  = succ;
    ref_nx   = ref_digit;
    digit_nx = digit;
    dv_nx    = 1'b0;
    ill_nx   = 1'b0;
    seq_nx   = 1'b0;
    err_inc  = 1'b0;
    wrap_nx  = wrap_cnt;
    if (in_valid) begin
      if (!legal) begin
        ill_nx   = 1'b1;
        err_inc  = 1'b1;
        state_nx = S_IDLE;
        succ_nx  = 4'd0;
      end else begin
        digit_nx = dec;
        dv_nx    = 1'b1;
        ref_nx   = dec;
        case (state)
          S_IDLE: begin
            state_nx = S_ACQUIRE;
            succ_nx  = 4'd0;
          end
          S_ACQUIRE: begin
            if (dec == exp_digit) begin
              succ_nx = succ_inc;
              if (succ_inc >= LOCK_W) state_nx = S_LOCKED;
            end else begin
              succ_nx = 4'd0;
            end
          end
          S_LOCKED: begin
            // A repeated digit fails the exp comparison, so it is a break too.
            if (dec == exp_digit) begin
              if (ref_digit == 4'd9) wrap_nx = wrap_cnt + WRAP_W'(1);
            end else begin
              seq_nx   = 1'b1;
              err_inc  = 1'b1;
              state_nx = S_ACQUIRE;
              succ_nx  = 4'd0;
            end
          end
          default: begin
            state_nx = S_IDLE;
            succ_nx  = 4'd0;
          end
        endcase
      end
    end
    err_nx = (err_inc && (err_cnt != {ERR_W{1'b1}})) ? err_cnt + ERR_W'(1) : err_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      succ        <= 4'd0;
      ref_digit   <= 4'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      wrap_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      succ        <= succ_nx;
      ref_digit   <= ref_nx;
      digit       <= digit_nx;
      digit_valid <= dv_nx;
      illegal     <= ill_nx;
      seq_err     <= seq_nx;
      wrap_cnt    <= wrap_nx;
      err_cnt     <= err_nx;
    end
  end

  assign locked    = (state == S_LOCKED);
  assign fsm_state = state;

endmodule

// File: tb/tb_code2421_seq_checker.sv
// Directed self-checking bench for code2421_seq_checker (LOCK_N=3, WRAP_W=8, ERR_W=8).
module tb_code2421_seq_checker;

  logic       clk;
  logic       rst;
  logic [3:0] code_in;
  logic       in_valid;
  logic [3:0] digit;
  logic       digit_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;
  logic [1:0] fsm_state;

  int checks;
  int errors;

  logic [3:0] enc [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                           4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
  logic [3:0] bad [6]  = '{4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

  code2421_seq_checker #(.LOCK_N(3), .WRAP_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid),
    .digit(digit), .digit_valid(digit_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .wrap_cnt(wrap_cnt),
    .err_cnt(err_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".digit"}, 32'(digit), 0);
    check_eq({tag, ".dv"}, 32'(digit_valid), 0);
    check_eq({tag, ".ill"}, 32'(illegal), 0);
    check_eq({tag, ".seq"}, 32'(seq_err), 0);
    check_eq({tag, ".lock"}, 32'(locked), 0);
    check_eq({tag, ".wrap"}, 32'(wrap_cnt), 0);
    check_eq({tag, ".err"}, 32'(err_cnt), 0);
    check_eq({tag, ".state"}, 32'(fsm_state), 0);
  endtask

  // driver: one sample, then check the registered response
  task automatic step(input string tag, input logic [3:0] c, input int e_digit,
                      input int e_dv, input int e_ill, input int e_seq, input int e_lock);
    @(negedge clk);
    code_in  = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, ".digit"}, 32'(digit), 32'(e_digit));
    check_eq({tag, ".dv"}, 32'(digit_valid), 32'(e_dv));
    check_eq({tag, ".ill"}, 32'(illegal), 32'(e_ill));
    check_eq({tag, ".seq"}, 32'(seq_err), 32'(e_seq));
    check_eq({tag, ".lock"}, 32'(locked), 32'(e_lock));
  endtask

  task automatic legal_step(input int d, input int e_seq, input int e_lock);
    step($sformatf("d%0d", d), enc[d], d, 1, 0, e_seq, e_lock);
  endtask

  task automatic idle_cycle(input int e_digit, input int e_lock);
    @(negedge clk);
    in_valid = 1'b0;
    code_in  = $urandom_range(15, 0);
    @(posedge clk);
    #1;
    check_eq("idle.digit", 32'(digit), 32'(e_digit));
    check_eq("idle.dv", 32'(digit_valid), 0);
    check_eq("idle.ill", 32'(illegal), 0);
    check_eq("idle.seq", 32'(seq_err), 0);
    check_eq("idle.lock", 32'(locked), 32'(e_lock));
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    code_in  = 4'd0;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // acquire and lock on 0..4: locked shows after the 4th sample
    legal_step(0, 0, 0);
    legal_step(1, 0, 0);
    legal_step(2, 0, 0);
    legal_step(3, 0, 1);
    legal_step(4, 0, 1);
    check_eq("acq.err", 32'(err_cnt), 0);
    check_eq("acq.wrap", 32'(wrap_cnt), 0);

    // locked stream through two decade wraps, ending on 0
    for (int k = 5; k <= 20; k++) legal_step(k % 10, 0, 1);
    check_eq("run.wrap", 32'(wrap_cnt), 2);
    check_eq("run.err", 32'(err_cnt), 0);
    for (int d = 1; d <= 6; d++) legal_step(d, 0, 1);

    // sequence break 6 -> 8, then relock via 9,0,1 (9->0 during ACQUIRE not counted)
    step("brk", 4'b1110, 8, 1, 0, 1, 0);
    check_eq("brk.err", 32'(err_cnt), 1);
    check_eq("brk.state", 32'(fsm_state), 1);
    legal_step(9, 0, 0);
    legal_step(0, 0, 0);
    check_eq("acqwrap.wrap", 32'(wrap_cnt), 2);
    legal_step(1, 0, 1);
    for (int d = 2; d <= 9; d++) legal_step(d, 0, 1);
    legal_step(0, 0, 1);
    check_eq("relock.wrap", 32'(wrap_cnt), 3);

    // illegal while locked: digit held, IDLE, no seq_err
    step("ill", 4'b1000, 0, 0, 1, 0, 0);
    check_eq("ill.err", 32'(err_cnt), 2);
    check_eq("ill.state", 32'(fsm_state), 0);
    idle_cycle(0, 0);
    legal_step(1, 0, 0);
    check_eq("post_ill.state", 32'(fsm_state), 1);
    check_eq("post_ill.err", 32'(err_cnt), 2);

    // mismatch in ACQUIRE restarts silently from the new value
    legal_step(9, 0, 0);
    check_eq("acqmis.err", 32'(err_cnt), 2);
    check_eq("acqmis.state", 32'(fsm_state), 1);
    legal_step(0, 0, 0);
    idle_cycle(0, 0);
    legal_step(1, 0, 0);
    legal_step(2, 0, 1);
    check_eq("acqmis.wrap", 32'(wrap_cnt), 3);

    // repeated digit while locked is a sequence error
    step("rep", enc[2], 2, 1, 0, 1, 0);
    check_eq("rep.err", 32'(err_cnt), 3);

    // saturate err_cnt with illegal codes
    for (int i = 0; i < 300; i++) begin
      step($sformatf("sat%0d", i), bad[i % 6], 2, 0, 1, 0, 0);
      check_eq("sat.err", 32'(err_cnt), (i + 4 > 255) ? 255 : i + 4);
    end

    // rebuild lock with five wraps, then async reset mid-clock
    do_reset();
    check_all_zero("reset2");
    for (int k = 0; k <= 52; k++) legal_step(k % 10, 0, (k >= 3) ? 1 : 0);
    check_eq("pre_arst.wrap", 32'(wrap_cnt), 5);
    #2;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1 check_all_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    step("after_arst", 4'b1011, 5, 1, 0, 0, 0);
    check_eq("after_arst.state", 32'(fsm_state), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
